// File: rtl/voice_mixer.sv
// voice_mixer: sums each NBANKS-slot frame of voice samples, scales and saturates it, and queues it for the codec
// Ports: clk, reset (async, active-high); clk_en slot strobe with i_sample;
//        o_data/o_valid/i_ready output handshake from a first-word-fall-through FIFO;
//        o_fill FIFO occupancy; o_clip saturation pulse; o_overflow sticky dropped-frame flag
module voice_mixer #(
    parameter int NBANKS     = 10,
    parameter int IN_W       = 24,
    parameter int ACC_W      = 28,
    parameter int SHIFT      = 2,
    parameter int SKIP       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [IN_W-1:0]               i_sample,
    output logic [23:0]                   o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill,
    output logic                          o_clip,
    output logic                          o_overflow
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(NBANKS);
    localparam int KW = $clog2(SKIP + 2);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(8388607);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-8388608);

    typedef enum logic {S_SKIP, S_ACCUM} state_t;

    state_t                   state;
    logic [KW-1:0]            skip_cnt;
    logic [SW-1:0]            slot;
    logic signed [ACC_W-1:0]  acc, r_sum, ext, acc_next, s;
    logic                     r_sum_valid;
    logic [23:0]              mem [FIFO_DEPTH];
    logic [FW-1:0]            wr_ptr, rd_ptr;
    logic                     sat_hi, sat_lo, full, pop, push_ok;
    logic [23:0]              result;

    always_comb begin
        ext      = {{(ACC_W-IN_W){i_sample[IN_W-1]}}, i_sample};
        acc_next = (slot == '0) ? ext : acc + ext;
        s        = r_sum >>> SHIFT;
        sat_hi   = s > MAX_V;
        sat_lo   = s < MIN_V;
        result   = sat_hi ? 24'h7FFFFF : sat_lo ? 24'h800000 : s[23:0];
        o_valid  = o_fill != '0;
        full     = o_fill == (FW+1)'(FIFO_DEPTH);
        pop      = o_valid && i_ready;
        // a full FIFO still accepts a push when the same edge frees a slot
        push_ok  = r_sum_valid && (!full || pop);
        o_data   = o_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= (SKIP > 0) ? S_SKIP : S_ACCUM;
            skip_cnt    <= KW'(SKIP);
            slot        <= '0;
            acc         <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_fill      <= '0;
            o_clip      <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (clk_en) begin
                if (state == S_SKIP) begin
                    skip_cnt <= skip_cnt - 1'b1;
                    if (skip_cnt == KW'(1)) begin
                        state <= S_ACCUM;
                        slot  <= '0;
                    end
                end else begin
                    acc <= acc_next;
                    if (slot == SW'(NBANKS - 1)) begin
                        slot        <= '0;
                        r_sum       <= acc_next;
                        r_sum_valid <= 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_fill     <= o_fill + (FW+1)'(push_ok) - (FW+1)'(pop);
            o_clip     <= push_ok && (sat_hi || sat_lo);
            o_overflow <= o_overflow || (r_sum_valid && !push_ok);
        end
    end

    always_ff @(posedge clk)
        if (push_ok)
            mem[wr_ptr] <= result;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed checks of frame summing, saturation, FIFO flow control, skip alignment and reset
module tb_voice_mixer;
    logic        clk = 0, reset = 1, clk_en = 0, i_ready = 0;
    logic [23:0] i_sample = '0;
    logic [23:0] data_a, data_b, data_c;
    logic        valid_a, valid_b, valid_c, clip_a, clip_b, clip_c, ovf_a, ovf_b, ovf_c;
    logic [2:0]  fill_a, fill_b, fill_c;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    voice_mixer #(.SHIFT(2), .SKIP(0)) u_a (.clk(clk), .reset(reset), .clk_en(clk_en), .i_sample(i_sample),
        .o_data(data_a), .o_valid(valid_a), .i_ready(i_ready), .o_fill(fill_a), .o_clip(clip_a), .o_overflow(ovf_a));
    voice_mixer #(.SHIFT(0), .SKIP(0)) u_b (.clk(clk), .reset(reset), .clk_en(clk_en), .i_sample(i_sample),
        .o_data(data_b), .o_valid(valid_b), .i_ready(i_ready), .o_fill(fill_b), .o_clip(clip_b), .o_overflow(ovf_b));
    voice_mixer #(.SHIFT(2), .SKIP(3)) u_c (.clk(clk), .reset(reset), .clk_en(clk_en), .i_sample(i_sample),
        .o_data(data_c), .o_valid(valid_c), .i_ready(i_ready), .o_fill(fill_c), .o_clip(clip_c), .o_overflow(ovf_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic send(input logic [23:0] v);
        clk_en   = 1;
        i_sample = v;
        tick();
        clk_en   = 0;
    endtask

    task automatic send_frame(input logic [23:0] first, input logic [23:0] rest);
        send(first);
        for (int i = 1; i < 10; i++) send(rest);
    endtask

    task automatic pop_b(input logic [23:0] exp);
        chk("pop_valid", 32'(valid_b), 1);
        chk("pop_data", 32'(data_b), 32'(exp));
        i_ready = 1;
        tick();
        i_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_fill", 32'(fill_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_clip", 32'(clip_a), 0);
        chk("rst_ovf", 32'(ovf_a), 0);

        // basic frame sum with SHIFT=2
        send_frame(24'h000400, 24'h000400);
        chk("t1_lat_valid", 32'(valid_a), 0);
        tick();
        chk("t1_valid", 32'(valid_a), 1);
        chk("t1_data", 32'(data_a), 32'h000A00);
        chk("t1_clip", 32'(clip_a), 0);
        chk("t1_fill", 32'(fill_a), 1);

        // saturation with SHIFT=0
        do_reset();
        send_frame(24'h7FFFFF, 24'h7FFFFF);
        tick();
        chk("t2_pos_clip", 32'(clip_b), 1);
        tick();
        chk("t2_pos_clip_pulse", 32'(clip_b), 0);
        pop_b(24'h7FFFFF);
        send_frame(24'h800000, 24'h800000);
        tick();
        chk("t2_neg_clip", 32'(clip_b), 1);
        pop_b(24'h800000);
        chk("t2_neg_clip_pulse", 32'(clip_b), 0);
        for (int i = 0; i < 10; i++) send(i[0] ? 24'hF00000 : 24'h100000);
        tick();
        chk("t2_alt_clip", 32'(clip_b), 0);
        pop_b(24'h000000);
        chk("t2_empty", 32'(valid_b), 0);

        // overflow: five frames into a four-entry FIFO
        do_reset();
        for (int k = 1; k <= 5; k++) send_frame(24'(k), 24'h0);
        tick();
        chk("t3_fill", 32'(fill_b), 4);
        chk("t3_ovf", 32'(ovf_b), 1);
        tick();
        chk("t3_hold_data", 32'(data_b), 1);
        for (int k = 1; k <= 4; k++) pop_b(24'(k));
        chk("t3_drained", 32'(valid_b), 0);
        chk("t3_ovf_sticky", 32'(ovf_b), 1);

        // simultaneous push and pop while full
        do_reset();
        for (int k = 1; k <= 4; k++) send_frame(24'(k), 24'h0);
        tick();
        chk("t4_full", 32'(fill_b), 4);
        send_frame(24'd5, 24'h0);
        i_ready = 1;
        tick();
        i_ready = 0;
        chk("t4_fill", 32'(fill_b), 4);
        chk("t4_ovf", 32'(ovf_b), 0);
        for (int k = 2; k <= 5; k++) pop_b(24'(k));
        chk("t4_drained", 32'(valid_b), 0);

        // skip alignment with gapped clk_en
        do_reset();
        for (int i = 0; i < 13; i++) begin
            int gap = 2 + int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            send(i < 3 ? 24'h7FFFFF : 24'h000010);
        end
        chk("t5_lat_valid", 32'(valid_c), 0);
        tick();
        chk("t5_valid", 32'(valid_c), 1);
        chk("t5_data", 32'(data_c), 32'h000028);
        chk("t5_clip", 32'(clip_c), 0);

        // asynchronous reset mid-frame with queued entries
        do_reset();
        send_frame(24'h8, 24'h0);
        send_frame(24'h8, 24'h0);
        tick();
        chk("t6_pre_fill", 32'(fill_a), 2);
        for (int i = 0; i < 5; i++) send(24'h000004);
        reset = 1;
        #1;
        chk("t6_rst_valid", 32'(valid_a), 0);
        chk("t6_rst_fill", 32'(fill_a), 0);
        chk("t6_rst_ovf", 32'(ovf_b), 0);
        tick();
        reset = 0;
        send_frame(24'h000004, 24'h000004);
        tick();
        chk("t6_fill", 32'(fill_a), 1);
        chk("t6_data", 32'(data_a), 32'h00000A);
        tick();
        tick();
        chk("t6_fill_hold", 32'(fill_a), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream stage of the pipelined bank manager.
- Consumes the time-multiplexed per-voice sample stream (one 24-bit signed sample per clk_en slot, NBANKS slots per frame) and sums each frame into a single mixed sample.
- Scales and saturates the sum, then buffers it in a small FIFO.
- Delivers samples to the audio codec interface through a valid/ready handshake.

Parameters:
NBANKS, 10, voice slots per frame; must match the bank manager
IN_W, 24, input sample width (signed)
ACC_W, 28, accumulator width; must be >= IN_W + ceil(log2(NBANKS))
SHIFT, 2, arithmetic right shift applied to the frame sum before saturation
SKIP, 0, clk_en samples discarded after reset to align frame boundary with bank manager pipeline latency
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  sample-slot strobe, same signal that drives the bank manager
i_sample  in  IN_W  signed voice sample for the current slot
o_data  out  24  signed mixed sample at FIFO head
o_valid  out  1  FIFO non-empty
i_ready  in  1  consumer accepts o_data when o_valid && i_ready at a clk edge
o_fill  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
o_clip  out  1  one-cycle pulse when a written sample was saturated
o_overflow  out  1  sticky; set when a frame result is dropped because the FIFO is full

Behaviour:
- Reset values (asynchronous): o_data=0, o_valid=0, o_fill=0, o_clip=0, o_overflow=0, accumulator=0, slot counter=0, skip counter=SKIP, FIFO pointers=0.
- Reset deasserted mid-frame or mid-handshake: all state is discarded with no partial output.
- The state machine has two states, S_SKIP and S_ACCUM.
  - After reset, the state is S_SKIP if SKIP>0, else S_ACCUM.
  - In S_SKIP, each clk_en decrements the skip counter and i_sample is ignored.
  - On the clk_en where the counter equals 1, the state goes to S_ACCUM with slot=0.
- In S_ACCUM on clk_en:
  - slot==0: acc <= sign-extend(i_sample).
  - Otherwise: acc <= acc + sign-extend(i_sample).
  - slot increments and wraps NBANKS-1 -> 0.
- On the clk_en edge E that consumes slot NBANKS-1:
  - r_sum <= acc + sign-extend(i_sample) (full ACC_W).
  - r_sum_valid <= 1 for exactly one cycle.
- Scaling and saturation (combinational from r_sum):
  - s = r_sum >>> SHIFT (arithmetic).
  - If s > 0x7FFFFF, the result is 0x7FFFFF; if s < -0x800000, the result is 0x800000; otherwise the result is s[23:0].
- At edge E+1, when r_sum_valid:
  - The result is pushed into the FIFO.
  - o_clip pulses high for the cycle after E+1 if saturation occurred.
  - o_valid is visible from E+1; total latency from last-slot sample to o_valid is 2 edges.
- FIFO behaviour:
  - o_data always shows the FIFO head (first-word fall-through).
  - Pop occurs on any edge with o_valid && i_ready.
  - Pop when empty: ignored.
  - Push when full and no pop on the same edge: the new result is dropped, FIFO contents are unchanged, and o_overflow is set until reset.
  - Push and pop on the same edge when full: both happen and occupancy stays FIFO_DEPTH.
  - Push and pop on the same edge when empty: the push is stored and o_valid goes high next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- clk_en low:
  - The accumulator, slot counter and skip counter hold.
  - The r_sum stage and the FIFO (push/pop/handshake) keep operating independently of clk_en.
- o_data holds its value while o_valid && !i_ready; the consumer must see a stable word.

Test Plan:
1. SHIFT=2, SKIP=0; ten clk_en samples of 0x000400 -> one FIFO entry 0x000A00, o_valid 2 edges after the 10th sample, o_clip=0.
2. SHIFT=0; ten samples of 0x7FFFFF -> o_data=0x7FFFFF with one o_clip pulse. Ten samples of 0x800000 -> o_data=0x800000 with one o_clip pulse. Alternating ±0x100000 -> 0x000000, no clip.
3. i_ready=0; 5 frames with per-frame values 1..5 (SHIFT=0) -> o_fill=4, o_overflow=1. Then i_ready=1 pops 1,2,3,4 in order and o_valid drops.
4. FIFO full with i_ready asserted exactly on the edge a new frame result is pushed -> o_fill stays 4, o_overflow stays 0, and the new value appears last in pop order.
5. SKIP=3, clk_en asserted every 3rd clk with random gaps; stream 3 junk samples 0x7FFFFF, then ten samples of 0x000010 -> first output 0x000028 with SHIFT=2 (160>>2 = 40), unaffected by the junk samples and the gaps.
6. Reset asserted after 5 samples of a frame and after 2 FIFO entries are queued -> o_valid=0, o_fill=0, o_overflow=0 immediately. After release, the next 10 samples of 0x000004 produce exactly one entry 0x00000A.
